// File: rtl/irq_agg_pkg.sv
// Shared constants, register map and priority helper for the interrupt aggregator.
package irq_agg_pkg;

  localparam int unsigned NUM_IRQ_MAX  = 16;
  localparam int unsigned IRQ_ID_W     = 4;
  localparam int unsigned ID_VALID_BIT = 15;

  typedef enum logic [2:0] {
    ADDR_PENDING = 3'd0,
    ADDR_MASK    = 3'd1,
    ADDR_EDGE    = 3'd2,
    ADDR_ACTIVE  = 3'd3,
    ADDR_ID      = 3'd4,
    ADDR_FORCE   = 3'd5
  } reg_addr_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IRQ_ID_W-1:0] lowest_set(input logic [NUM_IRQ_MAX-1:0] v);
    logic [IRQ_ID_W-1:0] id;
    logic                found;
    id    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ_MAX; i++) begin
      if (v[i] && !found) begin
        id    = IRQ_ID_W'(i);
        found = 1'b1;
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_aggregator_if.sv
// Avalon-MM slave register bus of the interrupt aggregator.
interface irq_aggregator_if;
  import irq_agg_pkg::*;

  logic [2:0]             address;
  logic                   chipselect;
  logic                   write_n;
  logic [NUM_IRQ_MAX-1:0] writedata;
  logic [NUM_IRQ_MAX-1:0] readdata;

  modport master (output address, output chipselect, output write_n,
                  output writedata, input readdata);
  modport slave  (input address, input chipselect, input write_n,
                  input writedata, output readdata);
endinterface

// File: rtl/irq_agg_line.sv
// One interrupt line: optional synchronizer (IRQ_AGG_SYNC_EN), edge detect and pending flag.
module irq_agg_line
`ifdef IRQ_AGG_SYNC_EN
  #(parameter int SYNC_STAGES = 2)
`endif
  (
  input  logic clk,
  input  logic reset_n,
  input  logic irq_in,
  input  logic edge_sel,
  input  logic clr,
  input  logic force_set,
  output logic pending
);

  logic s;
  logic prev;

`ifdef IRQ_AGG_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  // Synchronizer chain for sources outside this clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
  end

  assign s = sync_q[SYNC_STAGES-1];
`else
  assign s = irq_in;
`endif

  // Previous sample for edge detect; pending follows the level or latches edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev <= s;
      if (!edge_sel)                     pending <= s;
      else if ((s && !prev) || force_set) pending <= 1'b1;
      else if (clr)                      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator top: MASK/EDGE registers, read mux, priority encode, registered irq.
// Optional input synchronizers enabled by defining IRQ_AGG_SYNC_EN.
module irq_aggregator
  import irq_agg_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  irq_aggregator_if.slave     bus,
  input  logic [NUM_IRQ-1:0]  irq_in,
  output logic                irq_out,
  output logic [IRQ_ID_W-1:0] irq_id
);

  if (NUM_IRQ < 1 || NUM_IRQ > NUM_IRQ_MAX || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_param
    $error("irq_aggregator: NUM_IRQ or SYNC_STAGES out of range");
  end

  localparam logic [NUM_IRQ_MAX-1:0] LINE_MASK = NUM_IRQ_MAX'((64'd1 << NUM_IRQ) - 64'd1);

  logic                   wr_en;
  logic [NUM_IRQ_MAX-1:0] mask_q, edge_q;
  logic [NUM_IRQ_MAX-1:0] clr_x, force_x, pending_x, active_x;
  logic [NUM_IRQ-1:0]     pending;
  logic [NUM_IRQ_MAX-1:0] rd_mux;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign clr_x     = (wr_en && bus.address == ADDR_PENDING) ? (bus.writedata & LINE_MASK) : '0;
  assign force_x   = (wr_en && bus.address == ADDR_FORCE)   ? (bus.writedata & LINE_MASK) : '0;
  assign pending_x = NUM_IRQ_MAX'(pending);
  assign active_x  = pending_x & mask_q;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_agg_line
`ifdef IRQ_AGG_SYNC_EN
      #(.SYNC_STAGES(SYNC_STAGES))
`endif
      u_line (
        .clk       (clk),
        .reset_n   (reset_n),
        .irq_in    (irq_in[i]),
        .edge_sel  (edge_q[i]),
        .clr       (clr_x[i]),
        .force_set (force_x[i]),
        .pending   (pending[i])
      );
  end

  // Software-writable MASK and EDGE registers; bits above NUM_IRQ stay 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      edge_q <= '0;
    end else if (wr_en) begin
      if (bus.address == ADDR_MASK) mask_q <= bus.writedata & LINE_MASK;
      if (bus.address == ADDR_EDGE) edge_q <= bus.writedata & LINE_MASK;
    end
  end

  // Read mux, decoded from address alone; chipselect does not gate reads.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_PENDING: rd_mux = pending_x;
      ADDR_MASK:    rd_mux = mask_q;
      ADDR_EDGE:    rd_mux = edge_q;
      ADDR_ACTIVE:  rd_mux = active_x;
      ADDR_ID: begin
        rd_mux[ID_VALID_BIT]   = irq_out;
        rd_mux[IRQ_ID_W-1:0]   = irq_id;
      end
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data and aggregated interrupt outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      irq_out      <= 1'b0;
      irq_id       <= '0;
    end else begin
      bus.readdata <= rd_mux;
      irq_out      <= |active_x;
      irq_id       <= lowest_set(active_x);
    end
  end

endmodule

// File: tb/tb_irq_aggregator.sv
// Scoreboard bench for irq_aggregator: directed stimulus pushes timed expectations,
// a negedge monitor compares them against readdata or irq_out/irq_id.
module tb_irq_aggregator;

  localparam int NUM_IRQ     = 8;
  localparam int SYNC_STAGES = 2;
`ifdef IRQ_AGG_SYNC_EN
  localparam int LAT = SYNC_STAGES + 2;
`else
  localparam int LAT = 2;
`endif

  localparam logic [2:0] A_PEND = 3'd0, A_MASK = 3'd1, A_EDGE = 3'd2, A_ACT = 3'd3,
                         A_ID = 3'd4, A_FORCE = 3'd5, A_R6 = 3'd6, A_R7 = 3'd7;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NUM_IRQ-1:0] irq = '0;
  logic               irq_out;
  logic [3:0]         irq_id;
  int unsigned        cyc = 0;
  int unsigned        n_checks = 0;
  int unsigned        n_fail = 0;

  irq_aggregator_if bus ();

  irq_aggregator #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq_in  (irq),
    .irq_out (irq_out),
    .irq_id  (irq_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    bit          is_rd;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

  function automatic void push(input int unsigned due, input bit is_rd,
                               input logic [15:0] e, input string nm);
    exp_t x;
    x.due = due; x.is_rd = is_rd; x.exp = e; x.name = nm;
    sb.push_back(x);
  endfunction

  // Monitor: compare every expectation that falls due on this negedge.
  always @(negedge clk) begin : mon
    int unsigned k;
    logic [15:0] act;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].due <= cyc) begin
        act = sb[k].is_rd ? bus.readdata : {irq_out, 11'b0, irq_id};
        n_checks++;
        if (sb[k].due != cyc || act !== sb[k].exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (due %0d now %0d)",
                   sb[k].name, act, sb[k].exp, sb[k].due, cyc);
        end
        sb.delete(k);
      end else begin
        k++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    push(cyc + 1, 1'b1, e, nm);
    @(negedge clk);
    bus.chipselect = 1'b0;
  endtask

  task automatic exp_out(input int dly, input logic o, input logic [3:0] id, input string nm);
    push(cyc + dly, 1'b0, {o, 11'b0, id}, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    n_checks++;
    if (irq_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_irq_out: got %b expected 0", irq_out);
    end
    n_checks++;
    if (irq_id !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_irq_id: got %h expected 0", irq_id);
    end
    n_checks++;
    if (bus.readdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_readdata: got %h expected 0000", bus.readdata);
    end

    // Reset state and reserved addresses
    exp_out(1, 1'b0, 4'd0, "rst_out");
    rd(A_PEND, 16'h0000, "rst_pending");
    rd(A_MASK, 16'h0000, "rst_mask");
    rd(A_EDGE, 16'h0000, "rst_edge");
    rd(A_R6, 16'h0000, "rsvd6_rst");
    wr(A_R6, 16'hFFFF);
    rd(A_R6, 16'h0000, "rsvd6_wr");
    rd(A_R7, 16'h0000, "rsvd7");

    // Level mode on line 2
    wr(A_MASK, 16'h0004);
    irq = 8'h04;
    exp_out(LAT - 1, 1'b0, 4'd0, "lvl_pre");
    exp_out(LAT, 1'b1, 4'd2, "lvl_rise");
    tick(LAT + 1);
    n_checks++;
    if (irq_out !== 1'b1 || irq_id !== 4'd2) begin
      n_fail++;
      $display("FAIL lvl_direct: got %b/%h expected 1/2", irq_out, irq_id);
    end
    rd(A_PEND, 16'h0004, "lvl_pending");
    rd(A_ACT, 16'h0004, "lvl_active");
    rd(A_ID, 16'h8002, "lvl_id");
    wr(A_PEND, 16'h0004);
    exp_out(1, 1'b1, 4'd2, "lvl_w1c_out");
    rd(A_PEND, 16'h0004, "lvl_w1c_noeffect");
    irq = 8'h00;
    exp_out(LAT - 1, 1'b1, 4'd2, "lvl_fall_pre");
    exp_out(LAT, 1'b0, 4'd0, "lvl_fall");
    tick(LAT + 1);

    // Edge mode: one-cycle pulse on line 5 latches, W1C clears
    wr(A_EDGE, 16'h00FF);
    wr(A_MASK, 16'hFFFF);
    rd(A_MASK, 16'h00FF, "mask_upper_ignored");
    irq = 8'h20;
    exp_out(LAT, 1'b1, 4'd5, "edge_rise");
    tick(1);
    irq = 8'h00;
    tick(LAT + 2);
    exp_out(1, 1'b1, 4'd5, "edge_hold");
    rd(A_PEND, 16'h0020, "edge_latched");
    exp_out(1, 1'b1, 4'd5, "w1c_pre");
    exp_out(2, 1'b0, 4'd0, "w1c_clr");
    wr(A_PEND, 16'h0020);
    tick(2);
    rd(A_PEND, 16'h0000, "w1c_pending");

    // Set and clear in the same cycle on line 3: set wins
    irq = 8'h08;
    tick(LAT - 2);
    wr(A_PEND, 16'h0008);
    tick(1);
    rd(A_PEND, 16'h0008, "set_wins");
    irq = 8'h00;
    tick(LAT);
    wr(A_PEND, 16'h0008);
    tick(1);
    rd(A_PEND, 16'h0000, "set_wins_cleanup");

    // Priority between lines 1 and 6
    irq = 8'h42;
    tick(1);
    irq = 8'h00;
    tick(LAT + 2);
    rd(A_ID, 16'h8001, "prio_1");
    rd(A_ACT, 16'h0042, "prio_active");
    wr(A_PEND, 16'h0002);
    tick(2);
    rd(A_ID, 16'h8006, "prio_6");
    wr(A_PEND, 16'h0040);
    tick(2);
    rd(A_ID, 16'h0000, "prio_none");

    // MASK gating and MASK-write latency on line 7
    wr(A_MASK, 16'h007F);
    irq = 8'h80;
    tick(1);
    irq = 8'h00;
    tick(LAT + 2);
    rd(A_PEND, 16'h0080, "masked_pending");
    rd(A_ACT, 16'h0000, "masked_active");
    exp_out(1, 1'b0, 4'd0, "mask_pre");
    exp_out(2, 1'b1, 4'd7, "mask_on");
    wr(A_MASK, 16'h00FF);
    tick(2);
    wr(A_PEND, 16'h0080);
    tick(2);

    // FORCE on an edge line sets pending; on a level line it does nothing
    exp_out(1, 1'b0, 4'd0, "force_pre");
    exp_out(2, 1'b1, 4'd4, "force_out");
    wr(A_FORCE, 16'h0010);
    rd(A_FORCE, 16'h0000, "force_reads0");
    rd(A_PEND, 16'h0010, "force_pending");
    wr(A_PEND, 16'h0010);
    tick(2);
    wr(A_EDGE, 16'h007F);
    wr(A_FORCE, 16'h0080);
    tick(1);
    rd(A_PEND, 16'h0000, "force_level_ignored");

    // Asynchronous reset mid-operation with line 0 held high
    wr(A_EDGE, 16'h00FF);
    irq = 8'h01;
    exp_out(LAT, 1'b1, 4'd0, "pre_reset_out");
    tick(LAT + 1);
    reset_n = 1'b0;
    exp_out(1, 1'b0, 4'd0, "rst_mid_out");
    rd(A_MASK, 16'h0000, "rst_mid_read");
    reset_n = 1'b1;
    rd(A_MASK, 16'h0000, "post_rst_mask");
    rd(A_EDGE, 16'h0000, "post_rst_edge");
    tick(LAT);
    rd(A_PEND, 16'h0001, "post_rst_level");
    // Level->edge switch with the line high: pending retained, no re-trigger
    wr(A_EDGE, 16'h0001);
    rd(A_PEND, 16'h0001, "switch_retained");
    wr(A_PEND, 16'h0001);
    tick(1);
    rd(A_PEND, 16'h0000, "switch_no_retrigger");
    irq = 8'h00;

    tick(4);
    n_checks++;
    if (irq_out !== 1'b0) begin
      n_fail++;
      $display("FAIL end_irq_out: got %b expected 0", irq_out);
    end
    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got unsampled expected sample at %0d", sb[0].name, sb[0].due);
      void'(sb.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
